// File: rtl/pingpong_capture_pkg.sv
// pingpong_capture_pkg: capture FSM and trigger-mode enums plus the host register map.
package pingpong_capture_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_TRIG, FILL, HOLD} state_t;
    typedef enum logic [1:0] {MODE_RISE, MODE_FALL, MODE_FREE, MODE_RISE_ALT} mode_t;
    localparam logic [15:0] STATE_ADDR = 16'h4000;
    localparam logic [15:0] MODE_ADDR  = 16'h4001;
    localparam logic [15:0] DECIM_ADDR = 16'h4002;
endpackage

// File: rtl/pingpong_capture_ram.sv
// pingpong_capture_ram: simple dual-port sample store; each row holds one sample of every channel,
// rows {buf, idx}, one row-wide write port and a registered single-word read port.
module pingpong_capture_ram #(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH = 1024,
    parameter int CH_NUM = 2,
    parameter int AW = $clog2(2 * DEPTH),
    parameter int CW = CH_NUM > 1 ? $clog2(CH_NUM) : 1
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [AW-1:0]                waddr,
    input  logic [CH_NUM*DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]                raddr,
    input  logic [CW-1:0]                rch,
    output logic [DATA_WIDTH-1:0]        rdata
);
    logic [CH_NUM*DATA_WIDTH-1:0] mem [2*DEPTH];
    logic [CH_NUM*DATA_WIDTH-1:0] row_q;
    logic [CW-1:0] ch_q;
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        row_q <= mem[raddr];
        ch_q <= rch;
    end
    assign rdata = row_q[int'(ch_q)*DATA_WIDTH +: DATA_WIDTH];
endmodule

// File: rtl/pingpong_capture.sv
// pingpong_capture: triggered ping-pong ADC capture with host register/readback bus.
// Define PINGPONG_CAPTURE_DECIM_EN to add the DECIM register (0x4002) and sample decimation.
module pingpong_capture
    import pingpong_capture_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH = 1024,
    parameter int CH_NUM = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sample_valid,
    input  logic [CH_NUM*DATA_WIDTH-1:0] sample_data,
    input  logic                         stable,
    input  logic                         trig_in,
    input  logic                         en,
    input  logic                         addr_en,
    input  logic                         rd_en,
    input  logic                         wr_en,
    input  logic [15:0]                  rd_data,
    output logic [15:0]                  wr_data,
    output logic                         has_switched
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = CH_NUM > 1 ? $clog2(CH_NUM) : 1;
    localparam int SPAN = CH_NUM * DEPTH;

    state_t state, state_nx;
    mode_t mode;
    logic write_buf, buf_nx, lock, lock_nx, overrun, sw_nx, swap, we;
    logic [IW-1:0] write_ptr, ptr_nx;
    logic [15:0] addr, reg_val, reg_q, decim_rd;
    logic rd_en_q, trig_q, trig_qq, is_ram_q, store;
    logic host_wr, st_wr, edge_hit, start;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // A held rd_en commits only on its first cycle.
    assign host_wr = en & rd_en & ~rd_en_q;
    assign st_wr = host_wr & (addr == STATE_ADDR);
    assign lock_nx = st_wr ? rd_data[0] : lock;
    assign edge_hit = (mode == MODE_FALL) ? (trig_qq & ~trig_q) : (trig_q & ~trig_qq);
    assign start = edge_hit | (mode == MODE_FREE);

    always_comb begin
        state_nx = state;
        buf_nx = write_buf;
        ptr_nx = write_ptr;
        sw_nx = (st_wr & rd_data[0]) ? 1'b0 : has_switched;
        we = 1'b0;
        swap = 1'b0;
        case (state)
            IDLE: state_nx = stable ? WAIT_TRIG : IDLE;
            WAIT_TRIG: begin
                state_nx = !stable ? IDLE : start ? FILL : WAIT_TRIG;
                ptr_nx = '0;
            end
            FILL: begin
                if (!stable) begin
                    state_nx = IDLE;
                    ptr_nx = '0;
                end else if (store) begin
                    we = 1'b1;
                    if (write_ptr == IW'(DEPTH - 1)) begin
                        state_nx = lock_nx ? HOLD : state;
                        swap = ~lock_nx;
                    end else begin
                        ptr_nx = write_ptr + 1'b1;
                    end
                end
            end
            HOLD: swap = ~lock;
        endcase
        if (swap) begin
            buf_nx = ~write_buf;
            sw_nx = 1'b1;
            ptr_nx = '0;
            state_nx = WAIT_TRIG;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            write_buf <= 1'b0;
            write_ptr <= '0;
            lock <= 1'b0;
            overrun <= 1'b0;
            has_switched <= 1'b0;
            mode <= MODE_RISE;
            rd_en_q <= 1'b0;
            trig_q <= 1'b0;
            trig_qq <= 1'b0;
            addr <= '0;
        end else begin
            state <= state_nx;
            write_buf <= buf_nx;
            write_ptr <= ptr_nx;
            lock <= lock_nx;
            overrun <= (state == HOLD && edge_hit) || (overrun && !st_wr);
            has_switched <= sw_nx;
            if (host_wr && addr == MODE_ADDR) mode <= mode_t'(rd_data[1:0]);
            rd_en_q <= en & rd_en;
            trig_q <= trig_in;
            trig_qq <= trig_q;
            if (en && addr_en) addr <= rd_data;
        end
    end

`ifdef PINGPONG_CAPTURE_DECIM_EN
    logic [7:0] decim, dcnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            decim <= 8'd0;
            dcnt <= 8'd0;
        end else begin
            if (host_wr && addr == DECIM_ADDR) decim <= rd_data[7:0];
            dcnt <= (state != FILL) ? 8'd0 : !sample_valid ? dcnt : (dcnt == decim) ? 8'd0 : dcnt + 8'd1;
        end
    end
    assign store = sample_valid & (dcnt == 8'd0);
    assign decim_rd = {8'd0, decim};
`else
    assign store = sample_valid;
    assign decim_rd = 16'd0;
`endif

    assign reg_val = (addr == STATE_ADDR) ? {12'd0, overrun, lock, has_switched, write_buf} :
                     (addr == MODE_ADDR)  ? {14'd0, mode} :
                     (addr == DECIM_ADDR) ? decim_rd : 16'd0;

    // Stage 1 aligns register reads with the RAM read; stage 2 is the held output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            is_ram_q <= 1'b0;
            reg_q <= 16'd0;
            wr_data <= 16'd0;
        end else begin
            is_ram_q <= int'(addr) < SPAN;
            reg_q <= reg_val;
            if (!wr_en) wr_data <= is_ram_q ? 16'(ram_rdata) : reg_q;
        end
    end

    pingpong_capture_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH(DEPTH),
        .CH_NUM(CH_NUM)
    ) u_ram (
        .clk(clk),
        .we(we),
        .waddr({write_buf, write_ptr}),
        .wdata(sample_data),
        .raddr({~write_buf, addr[IW-1:0]}),
        .rch(addr[IW +: CW]),
        .rdata(ram_rdata)
    );
endmodule

// File: tb/tb_pingpong_capture.sv
// tb_pingpong_capture: randomized scoreboard bench against a buffer-level reference model.
module tb_pingpong_capture;
    localparam int DW = 12;
    localparam int DEPTH = 1024;
    localparam int CH = 2;
    localparam int MASK = (1 << DW) - 1;

    logic clk = 0, rst = 1, sample_valid = 0, stable = 0, trig_in = 0;
    logic en = 0, addr_en = 0, rd_en = 0, wr_en = 0;
    logic [CH*DW-1:0] sample_data = '0;
    logic [15:0] rd_data = '0;
    logic [15:0] wr_data;
    logic has_switched;

    always #5 clk = ~clk;

    pingpong_capture #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CH_NUM(CH)) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_data(sample_data),
        .stable(stable), .trig_in(trig_in), .en(en), .addr_en(addr_en), .rd_en(rd_en),
        .wr_en(wr_en), .rd_data(rd_data), .wr_data(wr_data), .has_switched(has_switched)
    );

    int passed = 0, total = 0;
    int exp_q[$];
    string name_q[$];
    int cur_exp = -1;
    string cur_name = "";
    logic wr_en_prev = 0;

    // Reference model: two physical buffers, the fill in progress and the host-visible flags.
    int phys [2][CH][DEPTH];
    bit pvalid [2];
    bit m_wb, m_hs, m_lock, m_ovr;
    int m_mode = 0, m_decim = 0, m_dc = 0, m_cnt = 0;
    int m_ph = 0;  // 0 idle, 1 waiting for trigger, 2 filling, 3 held by lock

    always @(negedge clk) begin
        if (wr_en) begin
            if (!wr_en_prev) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL read_unexpected: got %h with no expected value queued", wr_data);
                    cur_exp = -1;
                end else begin
                    cur_exp = exp_q.pop_front();
                    cur_name = name_q.pop_front();
                end
            end
            if (cur_exp >= 0) begin
                total++;
                if (wr_data == 16'(cur_exp)) passed++;
                else $display("FAIL %s: wr_data got %h expected %h", cur_name, wr_data, 16'(cur_exp));
            end
        end
        wr_en_prev = wr_en;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    task automatic m_start();
        m_ph = 2;
        m_cnt = 0;
        m_dc = 0;
        pvalid[m_wb] = 0;
    endtask

    task automatic m_swap();
        pvalid[m_wb] = 1;
        m_wb = !m_wb;
        m_hs = 1;
        m_ph = 1;
        if (m_mode == 2) m_start();
    endtask

    task automatic m_reset();
        if (m_ph == 2) pvalid[m_wb] = 0;
        m_wb = 0; m_hs = 0; m_lock = 0; m_ovr = 0; m_mode = 0; m_decim = 0;
        m_ph = stable ? 1 : 0;
    endtask

    task automatic put_sample(input int kind, input int i);
        int v [CH];
        bit keep;
        for (int c = 0; c < CH; c++) begin
            v[c] = kind == 0 ? ((c == 0 ? i : i * 3 + 7) & MASK) : int'($urandom) & MASK;
            sample_data[c*DW +: DW] = DW'(v[c]);
        end
        sample_valid = 1;
        if (m_ph == 2) begin
            keep = m_dc == 0;
            m_dc = m_dc == m_decim ? 0 : m_dc + 1;
            if (keep) begin
                for (int c = 0; c < CH; c++) phys[m_wb][c][m_cnt] = v[c];
                m_cnt++;
                if (m_cnt == DEPTH) begin
                    if (m_lock) m_ph = 3;
                    else m_swap();
                end
            end
        end
    endtask

    task automatic send_samples(input int n, input int kind);
        for (int i = 0; i < n; i++) begin
            put_sample(kind, i);
            tick();
            if ($urandom_range(0, 3) == 0) begin
                sample_valid = 0;
                tick();
            end
        end
        sample_valid = 0;
        tick();
    endtask

    task automatic set_trig(input logic v);
        bit e;
        e = m_mode == 1 ? (trig_in && !v) : (!trig_in && v);
        trig_in = v;
        if (m_ph == 1 && e) m_start();
        else if (m_ph == 3 && e) m_ovr = 1;
        repeat (3) tick();
    endtask

    task automatic set_stable(input logic v);
        stable = v;
        if (!v && (m_ph == 1 || m_ph == 2)) m_ph = 0;
        if (v && m_ph == 0) begin
            m_ph = 1;
            if (m_mode == 2) m_start();
        end
        repeat (2) tick();
    endtask

    task automatic host_write(input int a, input int d);
        en = 1; addr_en = 1; rd_data = 16'(a);
        tick();
        addr_en = 0; rd_en = 1; rd_data = 16'(d);
        if (a == 16'h4000) begin
            m_ovr = 0;
            m_lock = d[0];
            if (d[0]) m_hs = 0;
            if (m_ph == 3 && !m_lock) m_swap();
        end else if (a == 16'h4001) begin
            m_mode = d & 3;
            if (m_ph == 1 && m_mode == 2) m_start();
        end
`ifdef PINGPONG_CAPTURE_DECIM_EN
        else if (a == 16'h4002) m_decim = d & 255;
`endif
        tick();
        rd_data = ~16'(d);  // still-held rd_en must not write again
        tick();
        rd_en = 0; en = 0; rd_data = 0;
        repeat (2) tick();
    endtask

    task automatic host_read(input int a, input string nm);
        int e;
        if (a == 16'h4000) e = (int'(m_ovr) << 3) | (int'(m_lock) << 2) | (int'(m_hs) << 1) | int'(m_wb);
        else if (a == 16'h4001) e = m_mode;
`ifdef PINGPONG_CAPTURE_DECIM_EN
        else if (a == 16'h4002) e = m_decim;
`endif
        else if (a < CH * DEPTH) begin
            if (!pvalid[!m_wb]) return;
            e = phys[!m_wb][a / DEPTH][a % DEPTH];
        end else e = 0;
        en = 1; addr_en = 1; rd_data = 16'(a);
        tick();
        en = 0; addr_en = 0; rd_data = 0;
        repeat (2) tick();
        exp_q.push_back(e);
        name_q.push_back(nm);
        wr_en = 1;
        tick();
        en = 1; addr_en = 1; rd_data = 16'h4001;  // new address while held must not disturb wr_data
        tick();
        en = 0; addr_en = 0; rd_data = 0;
        repeat (2) tick();
        wr_en = 0;
        tick();
    endtask

    task automatic rand_reads(input int n);
        for (int k = 0; k < n; k++)
            host_read($urandom_range(0, CH - 1) * DEPTH + $urandom_range(0, DEPTH - 1), "rand_data");
    endtask

    task automatic lock_on_last();
        en = 1; addr_en = 1; rd_data = 16'h4000;
        tick();
        addr_en = 0; rd_en = 1; rd_data = 16'h0001;
        m_lock = 1; m_hs = 0; m_ovr = 0;
        put_sample(1, 0);
        tick();
        sample_valid = 0; rd_data = 0;
        tick();
        rd_en = 0; en = 0;
        repeat (2) tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        rst = 0;
        tick();
        host_read(16'h4000, "reset_status");
        host_read(16'h4001, "reset_mode");
        host_read(16'h4002, "reset_decim");
        chk("reset_has_switched", int'(has_switched), 0);

        set_stable(1);
        set_trig(1);
        send_samples(DEPTH, 0);
        host_read(16'h4000, "status_after_first_fill");
        host_read(5, "ramp_ch0_idx5");
        host_read(DEPTH + 5, "ramp_ch1_idx5");
        chk("has_switched_after_fill", int'(has_switched), int'(m_hs));
        rand_reads(3);
        set_trig(0);

        host_write(16'h4000, 1);
        chk("has_switched_cleared_by_lock", int'(has_switched), 0);
        set_trig(1);
        send_samples(DEPTH, 1);
        host_read(16'h4000, "status_hold");
        set_trig(0);
        set_trig(1);
        host_read(16'h4000, "status_overrun");
        rand_reads(2);
        host_write(16'h4000, 0);
        host_read(16'h4000, "status_after_unlock");
        rand_reads(3);

        set_trig(0);
        host_write(16'h4001, 1);
        host_read(16'h4001, "mode_fall");
        set_trig(1);
        send_samples(DEPTH, 1);
        host_read(16'h4000, "status_rise_ignored");
        set_trig(0);
        send_samples(DEPTH, 1);
        host_read(16'h4000, "status_after_fall_fill");
        rand_reads(3);

        set_trig(1);
        set_trig(0);
        send_samples(DEPTH - 1, 1);
        lock_on_last();
        host_read(16'h4000, "status_lock_priority");
        rand_reads(2);
        host_write(16'h4000, 0);
        host_read(16'h4000, "status_lock_release");
        rand_reads(2);

        host_write(16'h4001, 0);
        set_trig(1);
        send_samples(500, 1);
        set_stable(0);
        host_read(16'h4000, "status_after_stable_drop");
        rand_reads(3);
        set_stable(1);
        set_trig(0);
        set_trig(1);
        send_samples(DEPTH, 1);
        host_read(16'h4000, "status_refill");
        host_read(0, "refill_idx0");
        rand_reads(3);

        host_write(16'h3FFF, 16'h1234);
        host_write(16'h4003, 16'hFFFF);
        host_read(16'h3FFF, "unmapped_3fff");
        host_read(16'h4003, "unmapped_4003");
        host_read(16'h4000, "status_after_unmapped");
        host_write(16'h4002, 3);
        host_read(16'h4002, "decim_reg");
        set_trig(0);
        set_trig(1);
        send_samples(DEPTH * (m_decim + 1), 0);
        host_read(5, "decim_ramp_idx5");
        host_read(DEPTH + 5, "decim_ramp_ch1_idx5");
        host_read(DEPTH - 1, "decim_ramp_last");
        host_write(16'h4002, 0);

        host_write(16'h4001, 2);
        host_read(16'h4001, "mode_free");
        send_samples(DEPTH, 1);
        host_read(16'h4000, "status_free_run");
        rand_reads(3);

        send_samples(300, 1);
        rst = 1;
        tick();
        rst = 0;
        m_reset();
        tick();
        chk("has_switched_after_rst", int'(has_switched), 0);
        host_read(16'h4000, "status_after_rst");
        host_read(16'h3FFF, "addr_3fff_after_rst");
        host_read(16'h4001, "mode_after_rst");
        rand_reads(2);

        repeat (4) tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
